pio_in_capture: RTL and testbench
=================================

PIO_IN_CAPTURE -- requirements
Module: pio_in_capture

Interface
REQ-001 Parameter WIDTH, default 16, sets the input port width; legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, sets the per-bit stability count; legal range 0..255, where 0 bypasses debounce.
REQ-003 Parameter EDGE_MODE, default 0, selects the capture edge: 0 rising, 1 falling, 2 either.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 address  in  2  register select.
REQ-007 chipselect  in  1  slave select; qualifies write.
REQ-008 write  in  1  write strobe.
REQ-009 writedata  in  32  write data.
REQ-010 readdata  out  32  registered read data.
REQ-011 in_port  in  WIDTH  asynchronous external inputs (switches/keys).
REQ-012 irq  out  1  level interrupt.

Function
REQ-013 Register map SHALL be: 0 data (RO), 1 direction (reads 0, writes ignored), 2 irqmask (RW), 3 edgecapture (read; write-1-to-clear).
REQ-014 Each in_port bit SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-015 Per bit, debounce SHALL work as follows:
- s2==db: counter cleared.
- s2!=db and counter==DEBOUNCE_CYCLES-1: db<=s2, counter cleared.
- otherwise: counter increments.
REQ-016 With DEBOUNCE_CYCLES=0, db SHALL equal s2 registered, with no counter.
REQ-017 Latency, input stable before edge 0: db SHALL update at edge DEBOUNCE_CYCLES+1 (edge 1 when DEBOUNCE_CYCLES=0); readdata of address 0 SHALL reflect it one edge later.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES cycles at s2 SHALL leave db unchanged and SHALL clear the counter when it ends.
REQ-019 Edge detect SHALL compare db against db_prev (db delayed one cycle); a qualifying edge per EDGE_MODE SHALL set the edgecapture bit on the following edge.
REQ-020 Edgecapture bits SHALL stay set until cleared by a write to address 3 with the corresponding writedata bit at 1; writedata bits at 0 SHALL leave bits unchanged.
REQ-021 A new edge and a clear on the same bit in the same cycle SHALL leave the bit set (set wins).
REQ-022 A write to address 2 SHALL load irqmask from writedata[WIDTH-1:0]; writedata bits at WIDTH and above SHALL be ignored.
REQ-023 A write SHALL require chipselect=1 and write=1; otherwise no register changes.
REQ-024 readdata SHALL be updated every cycle from the current address; a 1-cycle read latency, zero-extended above WIDTH.
REQ-025 irq SHALL be the combinational OR of (edgecapture & irqmask) from registered state only.

Reset
REQ-026 While reset=1 at a clock edge, the following SHALL clear to 0: s1, s2, db, db_prev, all counters, irqmask, edgecapture, readdata.
REQ-027 irq SHALL be 0 during and immediately after reset.
REQ-028 An input held high through reset SHALL be detected as a rising edge after debounce.
REQ-029 Reset asserted mid-debounce SHALL abort the count with no db change.

Structure
REQ-030 Shared package pio_in_pkg SHALL hold:
- address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2, ADDR_EDGE=3
- EDGE_MODE encodings EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2
REQ-031 Per-bit synchronizer plus debounce SHALL be sub-module pio_in_debounce, instantiated WIDTH times by generate.

Verification (WIDTH=16, DEBOUNCE_CYCLES=4, EDGE_MODE=0 unless stated)
REQ-032 Stimulus: reset, in_port=16'h0000, then in_port=16'h00A5 held, address 0. Response: readdata=32'h000000A5 exactly 6 edges after the change; 0 before.
REQ-033 Stimulus: 3-cycle pulse on in_port[0]. Response: data stays 0, edgecapture stays 0, irq stays 0.
REQ-034 Stimulus: irqmask=16'h0001; in_port[0] rises and holds. Response: edgecapture=1 at edge 6, irq=1. Then write 32'h1 to address 3: edgecapture=0, irq=0 next cycle.
REQ-035 Stimulus: EDGE_MODE=1, in_port 16'hFFFF to 16'hFF00. Response: edgecapture=16'h00FF after debounce; a later 0-to-1 transition sets nothing.
REQ-036 Stimulus: clear-write to address 3 coinciding with a new edge on bit 2. Response: bit 2 remains 1.
REQ-037 Stimulus: write 32'hFFFF0003 to address 2, then read address 2 and address 1. Response: readdata=32'h00000003 and 32'h00000000.

Source files
------------

// File: rtl/pio_in_pkg.sv
// Shared constants for the PIO input-capture block: register map,
// capture-edge encodings and the edge qualification helper.
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Wide enough for the largest stability count (255).
  localparam int DB_CNT_W = 8;

  function automatic logic edge_hit(input int mode, input logic cur, input logic prev);
    case (mode)
      EDGE_FALL: return ~cur & prev;
      EDGE_ANY:  return cur ^ prev;
      default:   return cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/pio_in_debounce.sv
// One input bit: two-flop synchronizer followed by a stability counter that
// only lets the debounced level follow after DEBOUNCE_CYCLES differing samples.
module pio_in_debounce
  import pio_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic db_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din_i;
      s2_q <= s1_q;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // No filtering: the second synchronizer flop is the debounced level.
      assign db_o = s2_q;
    end else begin : g_count
      localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [DB_CNT_W-1:0] cnt_q;
      logic [DB_CNT_W-1:0] cnt_d;
      logic                db_q;
      logic                db_d;

      always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (s2_q == db_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          db_d  = s2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
          db_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          db_q  <= db_d;
        end
      end

      assign db_o = db_q;
    end
  endgenerate

endmodule

// File: rtl/pio_in_capture.sv
// Memory-mapped debounced input port with sticky edge capture, per-bit
// interrupt mask and a level interrupt; reads are registered (1-cycle latency).
module pio_in_capture
  import pio_in_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_prev_q;
  logic [WIDTH-1:0] edge_now;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      pio_in_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din_i (in_port[gi]),
        .db_o  (db[gi])
      );

      assign edge_now[gi] = edge_hit(EDGE_MODE, db[gi], db_prev_q[gi]);
    end
  endgenerate

  assign wr_en = chipselect & write;

  // A set in the same cycle as a clear wins, so no edge is ever lost.
  always_comb begin
    mask_d   = mask_q;
    clr_bits = '0;
    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGE)) begin
      clr_bits = writedata[WIDTH-1:0];
    end
    edge_d = (edge_q & ~clr_bits) | edge_now;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = db;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_prev_q  <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
    end else begin
      db_prev_q  <= db;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_q & mask_q);

  // Upper write-data bits carry no meaning when WIDTH < 32.
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_pio_in_capture.sv
// Self-checking bench: directed latency/corner sequences, a register-access
// vector table, and randomized traffic checked against a behavioural model.
module tb_pio_in_capture;
  import pio_in_pkg::*;

  localparam int W = 16;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata_f;
  logic [W-1:0] in_port;
  logic [W-1:0] in_port_f;
  logic        irq;
  logic        irq_f;

  always #5 clk = ~clk;

  pio_in_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(EDGE_RISE)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  pio_in_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(EDGE_FALL)) dut_f (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(readdata_f),
    .in_port(in_port_f), .irq(irq_f)
  );

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    step();
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  // Behavioural model: input seen two clocks late; the debounced level flips
  // once the last D synchronized samples all disagree with it.
  logic [W-1:0] m_s1, m_s2, m_db, m_dbp, m_ec, m_mask, m_db_n, m_flip, m_clr;
  logic [W-1:0] m_hist [D-1];
  logic [31:0]  m_rd;

  always_comb begin
    m_db_n = m_db;
    m_flip = '0;
    for (int b = 0; b < W; b++) begin
      m_flip[b] = (m_s2[b] != m_db[b]);
      for (int k = 0; k < D - 1; k++) begin
        if (m_hist[k][b] == m_db[b]) m_flip[b] = 1'b0;
      end
      if (m_flip[b]) m_db_n[b] = ~m_db[b];
    end
    m_clr = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_s1 <= '0; m_s2 <= '0; m_db <= '0; m_dbp <= '0;
      m_ec <= '0; m_mask <= '0; m_rd <= '0;
      for (int k = 0; k < D - 1; k++) m_hist[k] <= '0;
    end else begin
      m_s1 <= in_port;
      m_s2 <= m_s1;
      m_hist[0] <= m_s2;
      for (int k = 1; k < D - 1; k++) m_hist[k] <= m_hist[k-1];
      m_db  <= m_db_n;
      m_dbp <= m_db;
      m_ec  <= (m_ec & ~m_clr) | (m_db & ~m_dbp);
      if (chipselect && write && address == 2'd2) m_mask <= writedata[W-1:0];
      case (address)
        2'd0:    m_rd <= {16'h0, m_db};
        2'd2:    m_rd <= {16'h0, m_mask};
        2'd3:    m_rd <= {16'h0, m_ec};
        default: m_rd <= 32'h0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_readdata", readdata, m_rd);
      check("model_irq", 32'(irq), 32'(|(m_ec & m_mask)));
    end
  end

  typedef struct {
    logic        cs;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [11];

  initial begin
    // Starting state for the table: data=A5, edgecapture=A5, irqmask=0.
    vecs[0]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF0003, 32'h00000003, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 32'h00000000, 32'h00000000, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 2'd1, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 2'd3, 32'hFFFFFFFF, 32'h000000A5, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 2'd3, 32'hFFFFFFFF, 32'h000000A5, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 2'd3, 32'h00000001, 32'h000000A4, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 2'd2, 32'h00000080, 32'h00000080, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF0000, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 2'd2, 32'h00000020, 32'h00000020, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 2'd3, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 32'h00000000, 32'h000000A5, 1'b0};

    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write = 1'b0;
    writedata = 32'h0; in_port = '0; in_port_f = 16'hFFFF;
    repeat (3) step();
    cmp_en = 1'b1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    step();
    check("post_reset_irq", 32'(irq), 32'h0);
    check("post_reset_readdata", readdata, 32'h0);

    // Data latency: readdata follows at edge D+2 counting from edge 0.
    in_port = 16'h00A5;
    for (int k = 0; k <= 6; k++) begin
      step();
      check($sformatf("latency_edge%0d", k), readdata, (k == 6) ? 32'h000000A5 : 32'h0);
    end
    address = 2'd3;
    step();
    check("edge_after_rise", readdata, 32'h000000A5);

    for (int i = 0; i < 11; i++) begin
      chipselect = vecs[i].cs;
      write      = vecs[i].wr;
      address    = vecs[i].addr;
      writedata  = vecs[i].wd;
      step();
      chipselect = 1'b0;
      write      = 1'b0;
      step();
      check($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
    end

    // Short glitch on bit 0 must be filtered out.
    in_port = '0;
    repeat (10) step();
    bus_write(2'd2, 32'h1);
    address = 2'd0;
    in_port = 16'h0001;
    repeat (3) step();
    in_port = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("glitch_data", readdata, 32'h0);
      check("glitch_irq", 32'(irq), 32'h0);
    end
    address = 2'd3;
    step();
    check("glitch_edge", readdata, 32'h0);

    // Rise on bit 0 with mask set, then write-1-to-clear.
    in_port = 16'h0001;
    for (int k = 0; k <= 6; k++) begin
      step();
      check($sformatf("irq_edge%0d", k), 32'(irq), (k == 6) ? 32'h1 : 32'h0);
    end
    step();
    check("edge_bit0_set", readdata, 32'h1);
    bus_write(2'd3, 32'h1);
    check("irq_cleared", 32'(irq), 32'h0);
    step();
    check("edge_bit0_cleared", readdata, 32'h0);

    // Clear of bit 2 landing on the same edge as a new capture: set wins.
    in_port = 16'h0005;
    repeat (8) step();
    check("edge_bit2_first", readdata, 32'h4);
    in_port = 16'h0001;
    repeat (10) step();
    in_port = 16'h0005;
    repeat (6) step();
    bus_write(2'd3, 32'h4);
    step();
    check("set_wins", readdata, 32'h4);
    bus_write(2'd3, 32'h4);
    step();
    check("clear_after_set_wins", readdata, 32'h0);

    // Falling-edge instance: rise from reset not captured, 1->0 captured.
    step();
    check("fall_no_rise", readdata_f, 32'h0);
    in_port_f = 16'hFF00;
    repeat (8) step();
    check("fall_capture", readdata_f, 32'h000000FF);
    check("fall_irq", 32'(irq_f), 32'h1);
    in_port_f = 16'hFFFF;
    repeat (8) step();
    check("fall_ignores_rise", readdata_f, 32'h000000FF);

    // Reset in the middle of a debounce, input held high through reset.
    bus_write(2'd3, 32'hFFFF);
    in_port = '0;
    repeat (10) step();
    in_port = 16'h0003;
    repeat (3) step();
    reset = 1'b1;
    step();
    check("midreset_readdata", readdata, 32'h0);
    check("midreset_irq", 32'(irq), 32'h0);
    step();
    reset = 1'b0;
    address = 2'd0;
    for (int k = 0; k <= 6; k++) begin
      step();
      check($sformatf("rst_hold_edge%0d", k), readdata, (k == 6) ? 32'h3 : 32'h0);
    end
    address = 2'd3;
    step();
    check("rst_hold_rise", readdata, 32'h3);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 6) in_port = W'($urandom);
      else if (r < 12) in_port = in_port ^ (W'(1) << $urandom_range(0, W - 1));
      address    = 2'($urandom);
      chipselect = ($urandom_range(0, 3) == 0);
      write      = ($urandom_range(0, 3) == 0);
      writedata  = $urandom;
      reset      = ($urandom_range(0, 999) == 0);
      step();
    end
    reset = 1'b0;
    chipselect = 1'b0;
    write = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
